// File: rtl/booth_mac_seq_if.sv
// Operand/result handshake bundle for booth_mac_seq.
// slave  : the MAC unit side; master : the producer/consumer side.
interface booth_mac_seq_if #(
    parameter int N = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         acc_clear;
    logic         last;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_sat;

    modport slave (
        input  in_valid, a, b, acc_clear, last, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

    modport master (
        output in_valid, a, b, acc_clear, last, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/booth_mac_seq.sv
// Sequential radix-4 Booth multiply-accumulate unit.
// One operand pair per N/2+2 cycles; a rounded, saturated N-bit result is
// produced when the pair flagged 'last' has been accumulated.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for an operand pair, in_ready=1
// MUL    | N/2 Booth iterations, two multiplier bits per cycle
// ACC    | add product into accumulator, compute result if last
// OUT    | result held on out_data/out_sat until consumer takes it
module booth_mac_seq #(
    parameter int N     = 16,
    parameter int FRAC  = 10,
    parameter int GUARD = 8
) (
    input  logic             clk,
    input  logic             reset,
    booth_mac_seq_if.slave   bus,
    output logic             o_busy
);
    localparam int ACC_W = 2*N + GUARD;
    localparam int CNT_W = (N/2 > 1) ? $clog2(N/2) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N/2 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic        [ACC_W:0] ONE  = 1;
    localparam logic        [ACC_W:0] RND  = (FRAC == 0) ? '0 : (ONE << ((FRAC == 0) ? 0 : FRAC - 1));
    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-N+2){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-N+2){1'b1}}, {(N-1){1'b0}}};

    logic [1:0]              r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [N-1:0]            r_a;
    logic signed [N+1:0]     r_hi;      // upper partial product, N+2 bits so -2^(N-1)*2 is exact
    logic [N-1:0]            r_lo;      // multiplier bits shifting out, product low half shifting in
    logic                    r_bm1;     // b[2i-1] of the current triplet
    logic                    r_clear;
    logic                    r_last;
    logic signed [ACC_W-1:0] r_acc;
    logic [N-1:0]            r_out_data;
    logic                    r_out_sat;

    logic signed [N+1:0]     w_a1;
    logic signed [N+1:0]     w_a2;
    logic signed [N+1:0]     w_sel;
    logic signed [N+1:0]     w_pp;
    logic signed [2*N-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_acc_next;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_r;
    logic [N-1:0]            w_res;
    logic                    w_sat;

    assign w_a1 = {{2{r_a[N-1]}}, r_a};
    assign w_a2 = {r_a[N-1], r_a, 1'b0};

    // Booth digit selection from the current multiplier triplet
    always_comb begin
        w_sel = '0;
        case ({r_lo[1:0], r_bm1})
            3'b001, 3'b010: w_sel = w_a1;
            3'b011:         w_sel = w_a2;
            3'b100:         w_sel = -w_a2;
            3'b101, 3'b110: w_sel = -w_a1;
            default:        w_sel = '0;
        endcase
    end

    assign w_pp       = r_hi + w_sel;
    assign w_prod     = {r_hi[N-1:0], r_lo};
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_acc_next = r_clear ? w_prod_ext : r_acc + w_prod_ext;
    // one extra bit keeps the rounding add from wrapping near full scale
    assign w_rnd      = (ACC_W+1)'(w_acc_next) + $signed(RND);
    assign w_r        = w_rnd >>> FRAC;

    // Saturate the rounded accumulator to the N-bit output format
    always_comb begin
        w_res = w_r[N-1:0];
        w_sat = 1'b0;
        if (w_r > MAXV) begin
            w_res = {1'b0, {(N-1){1'b1}}};
            w_sat = 1'b1;
        end else if (w_r < MINV) begin
            w_res = {1'b1, {(N-1){1'b0}}};
            w_sat = 1'b1;
        end
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_a        <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_bm1      <= 1'b0;
            r_clear    <= 1'b0;
            r_last     <= 1'b0;
            r_acc      <= '0;
            r_out_data <= '0;
            r_out_sat  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_lo    <= bus.b;
                        r_hi    <= '0;
                        r_bm1   <= 1'b0;
                        r_cnt   <= '0;
                        r_clear <= bus.acc_clear;
                        r_last  <= bus.last;
                        r_state <= S_MUL;
                    end
                end
                S_MUL: begin
                    r_hi  <= w_pp >>> 2;
                    r_lo  <= {w_pp[1:0], r_lo[N-1:2]};
                    r_bm1 <= r_lo[1];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_ACC;
                    end
                end
                S_ACC: begin
                    r_acc <= w_acc_next;
                    if (r_last) begin
                        r_out_data <= w_res;
                        r_out_sat  <= w_sat;
                        r_state    <= S_OUT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_OUT);
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign o_busy        = (r_state != S_IDLE);

endmodule

// File: doc/booth_mac_seq.md
# booth_mac_seq

Sequential radix-4 Booth multiply-accumulate unit for the FC datapath. It is the parametrised successor of the single-shot fixed-point Booth multiplier: it takes signed fixed-point operand pairs over a valid/ready handshake and multiplies each in N/2 iterations. Products are summed into a wide guarded accumulator. On the last pair of a dot product it emits one rounded, saturated N-bit fixed-point result, with an overflow flag, to the activation stage.

## Interface
- N, 16: operand and result width; must be even and at least 4.
- FRAC, 10: fractional bits of operands and result, legal range 0..N-1; the raw product carries 2*FRAC fractional bits.
- GUARD, 8: extra accumulator headroom bits; ACC_W = 2N+GUARD.
- clk  in  1  clock, all state on rising edge.
- reset  in  1  reset, synchronous, active-high; clock clk.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  unit can accept a pair this cycle.
- a  in  N  signed multiplicand, Q(N-FRAC).FRAC.
- b  in  N  signed multiplier, same format.
- acc_clear  in  1  with accepted pair: accumulator is replaced by this product instead of summed.
- last  in  1  with accepted pair: this pair ends the dot product, so emit a result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_data  out  N  signed result, same format as operands.
- out_sat  out  1  out_data was clamped.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, ACC, OUT.
- IDLE: in_ready=1.
  - Accept when in_valid&in_ready. Latch a, b, acc_clear, last.
  - Product register P is cleared and the iteration counter is set to 0. Go to MUL.
- MUL: N/2 cycles. Each cycle:
  - Examine the Booth triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Add 0, ±a or ±2a to the upper partial product, which is N+2 bits wide so that a=-2^(N-1) is exact.
  - Arithmetic-shift right by 2.
  - After iteration N/2-1, P holds the exact signed 2N-bit a*b. Go to ACC.
- ACC: one cycle.
  - acc <= sext(P) if acc_clear, else acc + sext(P). ACC_W bits, wraps modulo 2^ACC_W with no overflow detection; GUARD sizing is the caller's responsibility.
  - If last: compute the result from the new acc value. Go to OUT.
  - Otherwise go to IDLE.
- Result computation:
  - r = (acc + 2^(FRAC-1)) >>> FRAC (round half up). For FRAC=0 no rounding term is added.
  - If r > 2^(N-1)-1: out_data=0x7FF..F, out_sat=1.
  - If r < -2^(N-1): out_data=0x80..0, out_sat=1.
  - Otherwise out_data=r[N-1:0], out_sat=0.
- OUT: out_valid=1; out_data and out_sat are held stable.
  - On out_valid&out_ready go to IDLE.
  - acc is retained; the next dot product must assert acc_clear.
- Inputs are ignored whenever in_ready=0.
- Reset:
  - State goes to IDLE; acc, P and counter go to 0.
  - Output values: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0.
  - Reset mid-MUL, mid-ACC or during OUT aborts the operation and discards any pending result, with no out_valid pulse.
  - Reset has priority over every handshake in the same cycle.

## Timing
- Accepting edge k; MUL occupies edges k+1..k+N/2; ACC at edge k+N/2+1.
- Non-last pair: in_ready rises after edge k+N/2+1, so sustained throughput is one pair per N/2+2 cycles (10 for N=16).
- Last pair: out_valid rises after edge k+N/2+1, i.e. latency N/2+2 edges.
- out_valid stays high until the out handshake; in_ready=1 is restored the cycle after that edge. There is no same-cycle accept-and-deliver.
- in_ready is a registered output with no combinational path from in_valid. out_valid does not depend combinationally on out_ready.
- While out_ready is low, out_data and out_sat must not change.

## Test plan
- **Basic product.** N=16, FRAC=10; a=0x0C00 (3.0), b=0x0200 (0.5), acc_clear=1, last=1 -> out_data=0x0600, out_sat=0, out_valid exactly 10 edges after accept.
- **Extreme operands.** a=b=0x8000 (-32.0) -> exact product +1024.0 is clamped to out_data=0x7FFF, out_sat=1. a=0x8000, b=0x7FFF -> out_data=0x8000, out_sat=1.
- **Accumulation.** Four pairs 0x0400×0x0400, clear on the first, last on the fourth -> a single out_valid with out_data=0x1000. No out_valid after pairs 1-3; in_ready returns every 10 cycles.
- **Rounding.** a=0x0001, b=0x0200 -> out_data=0x0001 (half rounds up). a=0xFFFF, b=0x0200 -> out_data=0x0000. a=0x0001, b=0x01FF -> 0x0000.
- **Backpressure.** Hold out_ready=0 for 5 cycles while driving in_valid=1 with new operands -> out_data and in_ready=0 stay stable and no pair is accepted. Handshake on cycle 6, then in_ready=1 on the next cycle.
- **Reset mid-operation.** Assert reset at the 3rd MUL cycle -> no out_valid, in_ready=1 after reset. Then one pair 0x0400×0x0800 with acc_clear=0, last=1 -> 0x0800, confirming acc was cleared.
